pc_unit: RTL

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with branch/jump/return selection and a circular return-address stack
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               STEP         = 4,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] branch_addr,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             call,
  output logic [WIDTH-1:0] pc,
  output logic             redirect,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  localparam logic [1:0] SEL_SEQ    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JUMP   = 2'd2;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             redirect_q, redirect_d;
  logic             err_q, err_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic             wr_en;
  logic [PW-1:0]    wr_idx;
  logic [WIDTH-1:0] seq_pc;
  logic [PW-1:0]    ptr_inc, ptr_dec;
  logic             ras_nonempty;
  logic             count_full;
  logic             pop;

  assign seq_pc       = pc_q + WIDTH'(STEP);
  assign ras_nonempty = (count_q != '0);
  assign count_full   = (count_q == CW'(RAS_DEPTH));
  assign pop          = !stall && (sel == 2'd3) && ras_nonempty;

  // ptr_q always addresses the top entry; wrap explicitly since RAS_DEPTH need not be a power of two
  assign ptr_inc = (ptr_q == PW'(RAS_DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  assign ptr_dec = (ptr_q == '0) ? PW'(RAS_DEPTH - 1) : ptr_q - PW'(1);

  always_comb begin
    pc_d       = pc_q;
    redirect_d = 1'b0;
    err_d      = err_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    wr_en      = 1'b0;
    wr_idx     = ptr_q;
    if (!stall) begin
      case (sel)
        SEL_SEQ: pc_d = seq_pc;
        SEL_BRANCH: begin
          pc_d       = branch_addr;
          redirect_d = 1'b1;
        end
        SEL_JUMP: begin
          pc_d       = jump_addr;
          redirect_d = 1'b1;
        end
        default: begin
          if (ras_nonempty) begin
            pc_d       = ras_q[ptr_q];
            redirect_d = 1'b1;
          end else begin
            pc_d  = seq_pc;
            err_d = 1'b1;
          end
        end
      endcase

      // Pop-then-push collapses to overwriting the top in place
      if (call) begin
        wr_en = 1'b1;
        if (!pop) begin
          ptr_d   = ptr_inc;
          wr_idx  = ptr_inc;
          count_d = count_full ? count_q : count_q + CW'(1);
        end
      end else if (pop) begin
        ptr_d   = ptr_dec;
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      redirect_q <= 1'b0;
      err_q      <= 1'b0;
      ptr_q      <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
      err_q      <= err_d;
      ptr_q      <= ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      ras_q[wr_idx] <= seq_pc;
    end
  end

  assign pc        = pc_q;
  assign redirect  = redirect_q;
  assign ras_empty = !ras_nonempty;
  assign ras_full  = count_full;
  assign ras_err   = err_q;

endmodule
